// File: rtl/vx_branch_resolve_unit_pkg.sv
// Shared types and helpers for the branch resolution path.
// Defaults describe the standard 4-warp, 32-bit configuration.
// br_rsv_t is the packed resolution record {wid, taken, dest}.
package vx_branch_resolve_unit_pkg;

  localparam int BR_NUM_WARPS = 4;
  localparam int BR_XLEN      = 32;

  // Warp-id width; a single-warp build still needs a 1-bit id.
  function automatic int nw_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BR_NW_W = nw_width(BR_NUM_WARPS);

  typedef struct packed {
    logic [BR_NW_W-1:0] wid;
    logic               taken;
    logic [BR_XLEN-1:0] dest;
  } br_rsv_t;

  localparam int BR_RSV_W = $bits(br_rsv_t);

endpackage

// File: rtl/vx_branch_fifo.sv
// Per-block resolution queue with fall-through when empty.
// Latency: 0 cycles when empty (head shows the incoming push), else 1.
// Backpressure: none upstream; the caller detects a push into a full queue.
module vx_branch_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         pass;
  logic         do_wr;
  logic         do_rd;

  // Wrap bit differs and index matches -> full; identical pointers -> empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // An empty queue presents the incoming entry so it can leave the same cycle.
  assign head  = empty ? push_dat : mem[rd_ptr[AW-1:0]];
  assign pass  = empty && push && pop;
  assign do_wr = push && !pass && (!full || pop);
  assign do_rd = pop && !empty;

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  // Pointer update; reset empties the queue immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/vx_branch_resolve_unit.sv
// Merges non-backpressurable ALU branch resolutions into one ready/valid stream, tracks stalled warps.
// Latency: br_valid in cycle N reaches rsv_valid in cycle N+1 when idle; 1 resolution per cycle.
// Backpressure: rsv_ready low holds rsv_*; producers cannot stall, a full block queue drops and flags.
module vx_branch_resolve_unit
  import vx_branch_resolve_unit_pkg::*;
#(
  parameter int  NUM_WARPS  = BR_NUM_WARPS,
  parameter int  NUM_BLOCKS = 1,
  parameter int  XLEN       = BR_XLEN,
  parameter int  FIFO_DEPTH = 2,
  localparam int NW_W       = nw_width(NUM_WARPS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BLOCKS-1:0]      br_valid,
  input  logic [NUM_BLOCKS*NW_W-1:0] br_wid,
  input  logic [NUM_BLOCKS-1:0]      br_taken,
  input  logic [NUM_BLOCKS*XLEN-1:0] br_dest,
  input  logic                       stall_set,
  input  logic [NW_W-1:0]            stall_wid,
  output logic                       rsv_valid,
  input  logic                       rsv_ready,
  output logic [NW_W-1:0]            rsv_wid,
  output logic                       rsv_taken,
  output logic [XLEN-1:0]            rsv_dest,
  output logic [NUM_WARPS-1:0]       stalled_mask,
  output logic                       err_overflow,
  output logic                       err_spurious,
  output logic [31:0]                taken_cnt,
  output logic [31:0]                ntaken_cnt
);

  localparam int PTR_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  // Same layout as br_rsv_t, sized from this instance's parameters.
  typedef struct packed {
    logic [NW_W-1:0] wid;
    logic            taken;
    logic [XLEN-1:0] dest;
  } rsv_t;

  localparam int RSV_W = $bits(rsv_t);

  rsv_t                  push_dat  [NUM_BLOCKS];
  rsv_t                  fifo_head [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] fifo_full;
  logic [NUM_BLOCKS-1:0] fifo_empty;
  logic [NUM_BLOCKS-1:0] fifo_avail;
  logic [NUM_BLOCKS-1:0] fifo_pop;
  logic [NUM_BLOCKS-1:0] fifo_drop;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant;
  logic [PTR_W-1:0]      grant_next;
  logic                  any_avail;
  int                    arb_idx;
  logic                  load;
  logic                  rsv_pop;
  rsv_t                  sel;
  logic [NUM_WARPS-1:0]  mask_nxt;

  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
    assign push_dat[b] = '{wid:   br_wid[b*NW_W +: NW_W],
                           taken: br_taken[b],
                           dest:  br_dest[b*XLEN +: XLEN]};

    vx_branch_fifo #(
      .W     (RSV_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (br_valid[b]),
      .push_dat (push_dat[b]),
      .pop      (fifo_pop[b]),
      .head     (fifo_head[b]),
      .full     (fifo_full[b]),
      .empty    (fifo_empty[b])
    );

    // A block has a candidate if it holds an entry or one is arriving right now.
    assign fifo_avail[b] = !fifo_empty[b] || br_valid[b];
    // Full with no simultaneous pop means the arriving entry has nowhere to go.
    assign fifo_drop[b]  = br_valid[b] && fifo_full[b] && !fifo_pop[b];
  end

  // Round-robin search starting at rr_ptr for the first block with a candidate.
  always_comb begin
    any_avail = 1'b0;
    grant     = '0;
    arb_idx   = 0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      arb_idx = int'(rr_ptr) + i;
      if (arb_idx >= NUM_BLOCKS) arb_idx = arb_idx - NUM_BLOCKS;
      if (!any_avail && fifo_avail[arb_idx[PTR_W-1:0]]) begin
        any_avail = 1'b1;
        grant     = arb_idx[PTR_W-1:0];
      end
    end
  end

  assign load       = (!rsv_valid || rsv_ready) && any_avail;
  assign rsv_pop    = rsv_valid && rsv_ready;
  assign sel        = fifo_head[grant];
  assign grant_next = (int'(grant) == NUM_BLOCKS - 1) ? '0 : grant + 1'b1;

  // Only the winning block is popped, and only when the output register loads.
  always_comb begin
    fifo_pop = '0;
    if (load) fifo_pop[grant] = 1'b1;
  end

  // Pointer moves past the winner on every load so blocks take turns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= grant_next;
    end
  end

  // Single-entry output stage; fields hold while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsv_valid <= 1'b0;
      rsv_wid   <= '0;
      rsv_taken <= 1'b0;
      rsv_dest  <= '0;
    end else if (load) begin
      rsv_valid <= 1'b1;
      rsv_wid   <= sel.wid;
      rsv_taken <= sel.taken;
      rsv_dest  <= sel.dest;
    end else if (rsv_ready) begin
      rsv_valid <= 1'b0;
    end
  end

  // Clear on pop first, then set on stall, so a re-stall of the same warp wins.
  always_comb begin
    mask_nxt = stalled_mask;
    if (rsv_pop)   mask_nxt[rsv_wid]   = 1'b0;
    if (stall_set) mask_nxt[stall_wid] = 1'b1;
  end

  // Stall mask, wrapping outcome counters and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stalled_mask <= '0;
      taken_cnt    <= '0;
      ntaken_cnt   <= '0;
      err_overflow <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      stalled_mask <= mask_nxt;
      if (rsv_pop && rsv_taken)  taken_cnt  <= taken_cnt + 32'd1;
      if (rsv_pop && !rsv_taken) ntaken_cnt <= ntaken_cnt + 32'd1;
      if (|fifo_drop) err_overflow <= 1'b1;
      if (rsv_pop && !stalled_mask[rsv_wid]) err_spurious <= 1'b1;
    end
  end

endmodule
